serial_pattern_tx: RTL and testbench

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

---
 rtl/serial_pattern_tx.sv | 113 +++++++++++
 tb/tb_serial_pattern_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: loads up to WIDTH bits and shifts them out LSB first, stallable by hold.
// Optional build macro SERIAL_PATTERN_EXPECT_EN adds a 3-bit history and the expect_o decode.
module serial_pattern_tx #(
    parameter int WIDTH = 10,
    parameter int LW    = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LW-1:0]    load_len,
    input  logic             hold,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             last,
    output logic             done,
    output logic [1:0]       expect_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [LW-1:0]    cnt;
    logic             accept;

    // Zero or oversize lengths mean "send the full frame".
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        if (len == '0 || len > LW'(WIDTH)) begin
            return LW'(WIDTH);
        end
        return len;
    endfunction

    assign accept = load_valid && load_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (bit_valid && cnt == LW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        bit_valid  = 1'b0;
        bit_out    = 1'b0;
        last       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: load_ready = 1'b1;
            SHIFT: begin
                bit_valid = !hold;
                bit_out   = shreg[0];
                last      = (cnt == LW'(1));
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= load_data;
            cnt   <= clamp_len(load_len);
        end else if (bit_valid) begin
            shreg <= shreg >> 1;
            cnt   <= cnt - LW'(1);
        end
    end

`ifdef SERIAL_PATTERN_EXPECT_EN
    // h1 is the most recently consumed bit; history spans frame boundaries.
    logic h1, h2, h3;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h1 <= 1'b0;
            h2 <= 1'b0;
            h3 <= 1'b0;
        end else if (bit_valid) begin
            h1 <= bit_out;
            h2 <= h1;
            h3 <= h2;
        end
    end

    assign expect_o = bit_valid ? {bit_out & h1 & h3, bit_out & ~h2 & ~h3} : 2'b00;
`else
    assign expect_o = 2'b00;
`endif

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: driver pushes expected bits, monitor pops on bit_valid.
module tb_serial_pattern_tx;
    localparam int WIDTH = 10;
    localparam int LW    = 4;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] load_data = '0;
    logic [LW-1:0]    load_len = '0;
    logic             hold = 1'b0;
    logic             bit_out;
    logic             bit_valid;
    logic             last;
    logic             done;
    logic [1:0]       expect_o;

    serial_pattern_tx #(.WIDTH(WIDTH), .LW(LW)) dut (
        .clock(clock), .reset_n(reset_n),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_len(load_len),
        .hold(hold), .bit_out(bit_out), .bit_valid(bit_valid),
        .last(last), .done(done), .expect_o(expect_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       b;
        logic       l;
        logic [1:0] e;
    } exp_t;

    exp_t       sb[$];
    logic       consumed[$];
    logic       obs_bit[$];
    logic [1:0] obs_exp[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // k-th most recent consumed bit (k=1 newest); zero before enough history.
    function automatic logic prev(input int k);
        if (consumed.size() < k) return 1'b0;
        return consumed[consumed.size() - k];
    endfunction

    function automatic logic [1:0] model_expect(input logic b);
`ifdef SERIAL_PATTERN_EXPECT_EN
        return {b & prev(1) & prev(3), b & !prev(2) & !prev(3)};
`else
        return 2'b00;
`endif
    endfunction

    task automatic check_reset_outputs();
        check("rst_load_ready", load_ready, 1);
        check("rst_bit_out", bit_out, 0);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_last", last, 0);
        check("rst_done", done, 0);
        check("rst_expect", expect_o, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset_n = 1'b0;
        load_valid = 1'b0;
        hold = 1'b0;
        #1 check_reset_outputs();
        sb.delete();
        consumed.delete();
        @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    // mode: 0 no hold, 1 random hold, 2 hold three cycles at bit 2. abort_bit<0 never aborts.
    task automatic send_frame(input logic [WIDTH-1:0] d, input logic [LW-1:0] l,
                              input int mode, input int abort_bit);
        int n, sent, held;
        logic [1:0] e;
        n = (l == 0 || l > WIDTH) ? WIDTH : int'(l);
        for (int i = 0; i < n; i++) begin
            e = model_expect(d[i]);
            sb.push_back('{b: d[i], l: (i == n - 1), e: e});
            consumed.push_back(d[i]);
        end
        @(negedge clock);
        check("idle_load_ready", load_ready, 1);
        load_valid = 1'b1;
        load_data  = d;
        load_len   = l;
        @(posedge clock);
        #1;
        load_valid = 1'($urandom_range(0, 1));
        load_data  = WIDTH'($urandom);
        load_len   = LW'($urandom);
        sent = 0;
        held = 0;
        while (sent < n) begin
            @(negedge clock);
            if (sent == abort_bit) begin
                reset_n = 1'b0;
                #1 check_reset_outputs();
                sb.delete();
                consumed.delete();
                load_valid = 1'b0;
                hold = 1'b0;
                @(posedge clock);
                #1 reset_n = 1'b1;
                @(negedge clock);
                #1 check("abort_no_done", done, 0);
                check("abort_ready", load_ready, 1);
                return;
            end
            case (mode)
                1: hold = ($urandom_range(0, 3) == 0);
                2: begin
                    hold = (sent == 2 && held < 3);
                    if (hold) held++;
                end
                default: hold = 1'b0;
            endcase
            #1;
            check("shift_bit_out", bit_out, d[sent]);
            check("shift_bit_valid", bit_valid, !hold);
            check("shift_last", last, (sent == n - 1));
            check("shift_ready", load_ready, 0);
            check("shift_done", done, 0);
            if (!hold) sent++;
        end
        @(negedge clock);
        hold = 1'($urandom_range(0, 1));
        #1;
        check("done_pulse", done, 1);
        check("done_ready", load_ready, 0);
        check("done_bit_valid", bit_valid, 0);
        check("done_bit_out", bit_out, 0);
        @(negedge clock);
        load_valid = 1'b0;
        hold = 1'b0;
        #1;
        check("after_done", done, 0);
        check("after_ready", load_ready, 1);
    endtask

    // Monitor: pops one expectation per consumed bit.
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            #2;
            if (reset_n && bit_valid) begin
                obs_bit.push_back(bit_out);
                obs_exp.push_back(expect_o);
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    x = sb.pop_front();
                    check("sb_bit_out", bit_out, x.b);
                    check("sb_last", last, x.l);
                    check("sb_expect", expect_o, x.e);
                end
            end
        end
    end

    initial begin
        int seq_a[10]  = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 1};
        int exp_a0[10] = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        int seq_b[4]   = '{1, 0, 1, 1};
        int exp_b[4]   = '{1, 0, 0, 2};
        int ab;

        #3 check_reset_outputs();
        @(posedge clock);
        #1 reset_n = 1'b1;

        obs_bit.delete();
        obs_exp.delete();
        send_frame(10'b1001100111, 4'd10, 0, -1);
        check("dirA_count", obs_bit.size(), 10);
        for (int i = 0; i < 10; i++) begin
            check("dirA_bit", obs_bit[i], seq_a[i]);
`ifdef SERIAL_PATTERN_EXPECT_EN
            check("dirA_expect", obs_exp[i], {1'b0, 1'(exp_a0[i])});
`else
            check("dirA_expect", obs_exp[i], 0);
`endif
        end

        do_reset();
        obs_bit.delete();
        obs_exp.delete();
        send_frame(10'b0000001101, 4'd4, 0, -1);
        check("dirB_count", obs_bit.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("dirB_bit", obs_bit[i], seq_b[i]);
`ifdef SERIAL_PATTERN_EXPECT_EN
            check("dirB_expect", obs_exp[i], exp_b[i]);
`else
            check("dirB_expect", obs_exp[i], 0);
`endif
        end

        send_frame(10'b1011001110, 4'd10, 2, -1);
        send_frame(10'b0110101011, 4'd0, 0, -1);
        send_frame(10'b1111100000, 4'd15, 1, -1);
        send_frame(10'b1010101010, 4'd10, 0, 5);
        send_frame(10'b0011110001, 4'd7, 0, -1);
        send_frame(10'b1100110011, 4'd1, 1, -1);

        for (int k = 0; k < 40; k++) begin
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : -1;
            send_frame(WIDTH'($urandom), LW'($urandom), int'($urandom_range(0, 2)), ab);
        end

        repeat (3) @(negedge clock);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
